// File: rtl/dpram_be_if.sv
// Bus bundle for both ports of dpram_be: port A/B strobes, lane enables, address, data,
// read data, ready and collision flag.
interface dpram_be_if #(
  parameter int unsigned addr_width_g = 14,
  parameter int unsigned data_width_g = 8,
  parameter int unsigned byte_width_g = 8
);
  localparam int unsigned NumBytes = data_width_g / byte_width_g;

  logic                    ram_we;
  logic [NumBytes-1:0]     ram_be;
  logic [addr_width_g-1:0] ram_ad;
  logic [data_width_g-1:0] ram_d;
  logic [data_width_g-1:0] ram_q;

  logic                    ram_we_b;
  logic [NumBytes-1:0]     ram_be_b;
  logic [addr_width_g-1:0] ram_ad_b;
  logic [data_width_g-1:0] ram_d_b;
  logic [data_width_g-1:0] ram_q_b;

  logic                    ram_ready;
  logic                    ram_collision;

  modport master (
    output ram_we, ram_be, ram_ad, ram_d,
    output ram_we_b, ram_be_b, ram_ad_b, ram_d_b,
    input  ram_q, ram_q_b, ram_ready, ram_collision
  );

  modport slave (
    input  ram_we, ram_be, ram_ad, ram_d,
    input  ram_we_b, ram_be_b, ram_ad_b, ram_d_b,
    output ram_q, ram_q_b, ram_ready, ram_collision
  );
endinterface

// File: rtl/dpram_be.sv
// True dual-port byte-enabled RAM with power-on clear sequencer and collision flag.
// Optional DPRAM_OUTREG_EN adds a second read register stage (2-cycle read latency).
module dpram_be #(
  parameter int unsigned             addr_width_g = 14,
  parameter int unsigned             data_width_g = 8,
  parameter int unsigned             byte_width_g = 8,
  parameter logic [data_width_g-1:0] clear_val_g  = '0
) (
  input logic       clk_sys,
  input logic       reset,
  dpram_be_if.slave bus
);
  localparam int unsigned Depth    = 2 ** addr_width_g;
  localparam int unsigned NumBytes = data_width_g / byte_width_g;

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StReady = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [addr_width_g-1:0] clr_cnt_q, clr_cnt_d;
  logic                    coll_q, coll_d;
  logic                    ready;
  logic                    clear_wr;
  logic                    wr_a, wr_b;
  logic [NumBytes-1:0]     lane_a, lane_b;
  logic [data_width_g-1:0] rd_a_q, rd_b_q;
  logic [data_width_g-1:0] mem [Depth];

  assign ready    = (state_q == StReady);
  assign clear_wr = (state_q == StClear) && !reset;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (reset) begin
      state_d   = StClear;
      clr_cnt_d = '0;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_cnt_d = clr_cnt_q + addr_width_g'(1);
          if (&clr_cnt_q) begin
            state_d = StReady;
          end
        end
        default: state_d = StReady;
      endcase
    end
  end

  // Port accesses are ignored until the clear has completed, and on any reset edge.
  always_comb begin
    wr_a   = ready && !reset && bus.ram_we;
    wr_b   = ready && !reset && bus.ram_we_b;
    lane_a = wr_a ? bus.ram_be : '0;
    lane_b = wr_b ? bus.ram_be_b : '0;
    coll_d = wr_a && wr_b && (bus.ram_ad == bus.ram_ad_b) && (|(lane_a & lane_b));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      coll_q    <= coll_d;
    end
  end

  // Port B lanes are written first so that port A wins on overlapping lanes.
  always_ff @(posedge clk_sys) begin
    if (clear_wr) begin
      mem[clr_cnt_q] <= clear_val_g;
    end else begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (lane_b[i]) begin
          mem[bus.ram_ad_b][i*byte_width_g +: byte_width_g] <=
            bus.ram_d_b[i*byte_width_g +: byte_width_g];
        end
      end
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (lane_a[i]) begin
          mem[bus.ram_ad][i*byte_width_g +: byte_width_g] <=
            bus.ram_d[i*byte_width_g +: byte_width_g];
        end
      end
    end
  end

  // Read-first: the old word is captured on the same edge that a write lands.
  always_ff @(posedge clk_sys) begin
    if (reset || !ready) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= mem[bus.ram_ad];
      rd_b_q <= mem[bus.ram_ad_b];
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [data_width_g-1:0] out_a_q, out_b_q;

  always_ff @(posedge clk_sys) begin
    if (reset || !ready) begin
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      out_a_q <= rd_a_q;
      out_b_q <= rd_b_q;
    end
  end

  assign bus.ram_q   = out_a_q;
  assign bus.ram_q_b = out_b_q;
`else
  assign bus.ram_q   = rd_a_q;
  assign bus.ram_q_b = rd_b_q;
`endif

  assign bus.ram_ready     = ready;
  assign bus.ram_collision = coll_q;
endmodule
